pipe_addsub: RTL and testbench

//  Parametrised, pipelined ripple-carry adder/subtractor; successor to the 4-bit combinational adder.

---
 rtl/pipe_addsub.sv | 124 ++++++++++++
 tb/tb_pipe_addsub.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor. The operand word is cut into SLICE-bit slices and one
// slice is resolved per stage, with the carry registered between stages. Upper operand slices
// travel down the pipe shifted so the slice being worked on is always in the low bits. The result
// accumulates by shifting in from the top, so after STAGES stages every bit sits in place.
// Valid/ready on both sides. The stall is global: the whole pipe freezes when the output is held.
module pipe_addsub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8  // WIDTH must be a multiple of SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned STAGES = WIDTH / SLICE;
  localparam int unsigned LAST   = STAGES - 1;

  logic stall;

  // Combinational view of what each stage works on this cycle.
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] r_in [STAGES];
  logic             c_in [STAGES];
  logic             v_in [STAGES];
  logic [SLICE:0]   sum  [STAGES];
  logic [WIDTH-1:0] r_nx [STAGES];

  // Stage registers. The rank at LAST is the output register.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  logic ovf_d, ovf_q;
  logic zero_d, zero_q;

  assign stall    = v_q[LAST] && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Subtract is folded in here so later stages never look at op.
      assign a_in[k] = x;
      assign b_in[k] = op ? ~y : y;
      assign c_in[k] = op ? ~cin : cin;
      assign r_in[k] = '0;
      assign v_in[k] = in_valid;
    end else begin : g_body
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign r_in[k] = r_q[k-1];
      assign v_in[k] = v_q[k-1];
    end

    assign sum[k]  = {1'b0, a_in[k][SLICE-1:0]} + {1'b0, b_in[k][SLICE-1:0]}
                   + {{SLICE{1'b0}}, c_in[k]};
    // New slice enters at the top; earlier slices move down one slot.
    assign r_nx[k] = (r_in[k] >> SLICE) | (WIDTH'(sum[k][SLICE-1:0]) << (WIDTH - SLICE));

    // Stage register: advance on no stall, load payload only for valid beats.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end else if (!stall) begin
        v_q[k] <= v_in[k];
        if (v_in[k]) begin
          a_q[k] <= a_in[k] >> SLICE;
          b_q[k] <= b_in[k] >> SLICE;
          c_q[k] <= sum[k][SLICE];
          r_q[k] <= r_nx[k];
        end
      end
    end
  end

  // Final-stage flags: signed overflow when both addends share a sign the sum does not.
  always_comb begin
    ovf_d  = 1'b0;
    zero_d = 1'b0;
    ovf_d  = (a_in[LAST][SLICE-1] == b_in[LAST][SLICE-1]) &&
             (sum[LAST][SLICE-1] != a_in[LAST][SLICE-1]);
    zero_d = (r_nx[LAST] == '0);
  end

  // Flag registers, updated alongside the output rank.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (!stall && v_in[LAST]) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign s         = r_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Operands have been fully consumed by the time they reach the output rank.
  logic unused_tail_ops;
  assign unused_tail_ops = ^{a_q[LAST], b_q[LAST]};

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub (WIDTH=32, SLICE=8). Fixed vectors with hand-computed results,
// a backpressure sequence, random traffic against a reference model, and reset with beats in flight.
module tb_pipe_addsub;

  localparam int unsigned W   = 32;
  localparam int          LAT = 4;
  localparam int          NV  = 14;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           cyc;
    bit           lat;
  } exp_t;

  typedef struct {
    logic         op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         zero;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  vec_t tbl [NV];

  pipe_addsub #(
    .WIDTH(32),
    .SLICE(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .x        (x),
    .y        (y),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .s        (s),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference: carry into the MSB taken from a separate (W-1)-bit sum.
  function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c);
    exp_t         e;
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   full;
    logic [W-1:0] low;
    bb     = o ? ~b : b;
    cc     = o ? ~c : c;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
    low    = {1'b0, a[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, cc};
    e.s    = full[W-1:0];
    e.cout = full[W];
    e.ovf  = low[W-1] ^ full[W];
    e.zero = (full[W-1:0] == '0);
    e.cyc  = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  function automatic vec_t mk(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic c, input logic [W-1:0] rs, input logic rc,
                              input logic rv, input logic rz);
    vec_t v;
    v.op = o;  v.x = a;     v.y = b;    v.cin = c;
    v.s  = rs; v.cout = rc; v.ovf = rv; v.zero = rz;
    return v;
  endfunction

  task automatic drive(input logic v, input logic o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c);
    in_valid = v;
    op       = o;
    x        = a;
    y        = b;
    cin      = c;
  endtask

  // Record the beat if it is accepted this cycle, then step to just after the next rising edge.
  task automatic finish_cycle(input exp_t e, output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready && !rst;
    if (acc) begin
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every delivered beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got s=%h, required no beat", s);
      end else begin
        e = sb.pop_front();
        check("result", {29'd0, s, cout, ovf, zero}, {29'd0, e.s, e.cout, e.ovf, e.zero});
        if (e.lat) check("latency", 64'(cyc), 64'(e.cyc + LAT));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: still running, required finish");
    $fatal(1);
  end

  initial begin
    bit           acc;
    int           bi;
    bit           stalled_prev;
    logic [34:0]  snap;
    exp_t         e;

    tbl[0]  = mk(1'b0, 32'd2,         32'd3,         1'b0, 32'd5,         1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 32'hFFFF_FFFF, 32'd1,         1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    tbl[2]  = mk(1'b0, 32'h7FFF_FFFF, 32'd1,         1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(1'b1, 32'd7,         32'd5,         1'b0, 32'd2,         1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(1'b1, 32'd5,         32'd7,         1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 32'd5,         32'd2,         1'b1, 32'd2,         1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 32'h8000_0000, 32'd1,         1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 32'h00FF_FFFF, 32'd1,         1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 32'h0000_FFFF, 32'd1,         1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 32'h0000_00FF, 32'd1,         1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 32'hFFFF_FFFF, 32'd0,         1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    tbl[11] = mk(1'b1, 32'd0,         32'd0,         1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    tbl[12] = mk(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    tbl[13] = mk(1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

    // Reset state
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", {29'd0, s, cout, ovf, zero}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Fixed vectors, one isolated beat each, latency checked
    for (int i = 0; i < NV; i++) begin
      e.s    = tbl[i].s;
      e.cout = tbl[i].cout;
      e.ovf  = tbl[i].ovf;
      e.zero = tbl[i].zero;
      e.cyc  = 0;
      e.lat  = 1'b1;
      drive(1'b1, tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].cin);
      finish_cycle(e, acc);
      check("tbl_accept", 64'(acc), 64'd1);
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      for (int t = 0; t < LAT + 1; t++) finish_cycle(e, acc);
      check("tbl_single_pulse", 64'(out_valid), 64'd0);
    end

    // Six back-to-back beats with out_ready low for three cycles once results arrive
    bi           = 0;
    stalled_prev = 1'b0;
    snap         = '0;
    for (int t = 0; t < 16; t++) begin
      logic         o;
      logic         c;
      logic [W-1:0] a;
      logic [W-1:0] b;
      o         = bi[0];
      c         = bi[1];
      a         = 32'h1000_0000 + 32'h0101_0101 * bi;
      b         = 32'h00FF_00FF * bi;
      out_ready = !(t >= 5 && t <= 7);
      drive(bi < 6, o, a, b, c);
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'(!(t >= 5 && t <= 7)));
      if (stalled_prev) check("stall_hold", {29'd0, s, cout, ovf, zero}, {29'd0, snap});
      if (in_valid && in_ready) begin
        e     = model(o, a, b, c);
        e.cyc = cyc;
        sb.push_back(e);
        bi++;
      end
      stalled_prev = out_valid && !out_ready;
      snap         = {s, cout, ovf, zero};
      @(posedge clk);
      #1;
    end
    check("stall_all_accepted", 64'(bi), 64'd6);
    check("stall_drained", 64'(sb.size()), 64'd0);

    // Random traffic and backpressure
    for (int t = 0; t < 80; t++) begin
      logic         o;
      logic         c;
      logic [W-1:0] a;
      logic [W-1:0] b;
      o = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      a = $urandom();
      b = $urandom();
      if (t % 7 == 3) b = a;
      out_ready = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, o, a, b, c);
      finish_cycle(model(o, a, b, c), acc);
    end
    out_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    for (int t = 0; t < 10; t++) finish_cycle(e, acc);
    check("random_drained", 64'(sb.size()), 64'd0);

    // Make the output register non-zero before the mid-flight reset
    drive(1'b1, 1'b0, 32'h0000_1234, 32'h0000_0001, 1'b0);
    finish_cycle(model(1'b0, 32'h0000_1234, 32'h0000_0001, 1'b0), acc);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    for (int t = 0; t < LAT + 1; t++) finish_cycle(e, acc);

    // Reset with three beats in flight
    for (int t = 0; t < 3; t++) begin
      drive(1'b1, 1'b0, 32'(t + 1), 32'h0000_0010, 1'b0);
      finish_cycle(model(1'b0, 32'(t + 1), 32'h0000_0010, 1'b0), acc);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_outputs", {29'd0, s, cout, ovf, zero}, 64'd0);
    for (int t = 0; t < 8; t++) finish_cycle(e, acc);

    e     = model(1'b1, 32'h0000_0100, 32'h0000_0001, 1'b0);
    e.lat = 1'b1;
    drive(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0001, 1'b0);
    finish_cycle(e, acc);
    check("postrst_accept", 64'(acc), 64'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    for (int t = 0; t < LAT + 2; t++) finish_cycle(e, acc);
    check("postrst_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
